// File: rtl/pix_line_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pix_line_fifo_pkg : helpers shared by the pixel line FIFO
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package pix_line_fifo_pkg;

   // A RAM read may only issue if its data will find a free output slot on return.
   function automatic logic f_read_room(input logic [1:0] out_cnt,
                                        input logic       pend,
                                        input logic       pop);
      logic [2:0] v_occ;
      v_occ = {1'b0, out_cnt} + {2'b00, pend} - {2'b00, pop};
      return (v_occ < 3'd2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pix_line_fifo_ram.sv
// -----------------------------------------------------------------------------
// Dul_Ram : 2**L x DW simple dual-port RAM, registered read, single clock
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module Dul_Ram #(
   parameter int L  = 8,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [L-1:0]  i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [L-1:0]  i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(2**L)-1];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/pix_line_fifo.sv
// -----------------------------------------------------------------------------
// pix_line_fifo : first-word-fall-through pixel FIFO, RAM plus 2-entry skid
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pix_line_fifo
   import pix_line_fifo_pkg::*;
#(
   parameter int L      = 8,
   parameter int DW     = 24,
   parameter int AF_THR = 2**L - 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready,
   output logic [L:0]    level,
   output logic          afull
);

   localparam logic [L:0] c_cap    = {1'b1, {L{1'b0}}};
   localparam logic [L:0] c_af_thr = (L+1)'(AF_THR);

   logic [L:0]    r_wr_ptr;
   logic [L:0]    r_rd_ptr;
   logic [L:0]    r_level;
   logic          r_pend;
   logic          r_head_v;
   logic          r_skid_v;
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_skid;

   logic [L:0]    w_ram_cnt;
   logic [1:0]    w_out_cnt;
   logic          w_push;
   logic          w_pop;
   logic          w_rd_issue;
   logic [DW-1:0] w_rdata;
   logic          w_head_load;

   assign w_ram_cnt   = r_wr_ptr - r_rd_ptr;
   assign w_out_cnt   = {1'b0, r_head_v} + {1'b0, r_skid_v};
   assign w_push      = s_valid && s_ready;
   assign w_pop       = r_head_v && m_ready;
   assign w_rd_issue  = (w_ram_cnt != '0) && f_read_room(w_out_cnt, r_pend, w_pop);
   // Returning data goes to head only when head is (or is becoming) free and skid is empty.
   assign w_head_load = r_pend && (!r_head_v || (w_pop && !r_skid_v));

   assign s_ready = (r_level != c_cap);
   assign m_valid = r_head_v;
   assign m_data  = r_head;
   assign level   = r_level;
   assign afull   = (r_level >= c_af_thr);

   Dul_Ram #(
      .L  (L),
      .DW (DW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push && rst_n && !flush),
      .i_waddr (r_wr_ptr[L-1:0]),
      .i_wdata (s_data),
      .i_re    (w_rd_issue),
      .i_raddr (r_rd_ptr[L-1:0]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_pend   <= 1'b0;
         r_head_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_pend <= w_rd_issue;

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase

         if (w_pop) begin
            r_head_v <= r_skid_v || r_pend;
            r_skid_v <= r_skid_v && r_pend;
         end else if (r_pend) begin
            r_head_v <= 1'b1;
            r_skid_v <= r_head_v;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_pop && r_skid_v) begin
            r_head <= r_skid;
         end else if (w_head_load) begin
            r_head <= w_rdata;
         end
         if (r_pend && !w_head_load) begin
            r_skid <= w_rdata;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pix_line_fifo.sv
// -----------------------------------------------------------------------------
// tb_pix_line_fifo : scoreboard bench for pix_line_fifo (L=4, DW=24, AF_THR=12)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pix_line_fifo;

   localparam int L      = 4;
   localparam int DW     = 24;
   localparam int AF_THR = 12;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          flush   = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data  = '0;
   logic          m_ready = 1'b0;
   logic          s_ready;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [L:0]    level;
   logic          afull;

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] exp_q[$];
   logic          hold_v = 1'b0;
   logic [DW-1:0] hold_d = '0;
   logic          done   = 1'b0;

   pix_line_fifo #(
      .L      (L),
      .DW     (DW),
      .AF_THR (AF_THR)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready),
      .level   (level),
      .afull   (afull)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] v);
      bit hs;
      int n;
      s_valid = 1'b1;
      s_data  = v;
      n       = 0;
      do begin
         @(negedge clk);
         hs = s_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!hs && n < 300);
      if (!hs) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      m_ready = 1'b1;
      while (level != 0 && n < 100) begin
         step();
         n++;
      end
      @(negedge clk);
      chk(nm, level, 0);
   endtask

   // Scoreboard monitor: pop compares before push so a same-cycle bypass is caught.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         exp_q.delete();
      end else begin
         if (hold_v) begin
            chk("stall_valid_hold", m_valid, 1);
            chk("stall_data_hold", m_data, hold_d);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected actual=%0h required=none", m_data);
            end else begin
               chk("sb_data", m_data, exp_q.pop_front());
            end
         end
         if (s_valid && s_ready) exp_q.push_back(s_data);
      end
      hold_v = rst_n && !flush && m_valid && !m_ready;
      hold_d = m_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  v;
      bit  hs;

      // reset state
      rst_n = 1'b0;
      repeat (2) step();
      @(negedge clk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_afull", afull, 0);
      chk("rst_level", level, 0);
      step();
      rst_n = 1'b1;
      step();

      // single word latency
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = 24'hA5A5A5;
      step();
      s_valid = 1'b0;
      @(negedge clk);
      chk("lat_level_n", level, 1);
      chk("lat_mvalid_n", m_valid, 0);
      @(negedge clk);
      chk("lat_level_n1", level, 1);
      chk("lat_mvalid_n1", m_valid, 0);
      @(negedge clk);
      chk("lat_mvalid_n2", m_valid, 1);
      chk("lat_mdata_n2", m_data, 24'hA5A5A5);
      @(negedge clk);
      chk("lat_level_after_pop", level, 0);
      chk("lat_mvalid_after_pop", m_valid, 0);

      // fill to capacity
      step();
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(i);
         step();
         @(negedge clk);
         chk("fill_level", level, i + 1);
         chk("fill_afull", afull, (i + 1 >= AF_THR) ? 1 : 0);
      end
      chk("full_s_ready", s_ready, 0);
      s_data = 24'hEEEEEE;
      step();
      @(negedge clk);
      chk("full_17th_level", level, 16);

      // full-rate streaming from full
      step();
      v = 16;
      m_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         s_valid = 1'b1;
         s_data  = DW'(v);
         @(negedge clk);
         chk("stream_m_valid", m_valid, 1);
         if (c >= 1) chk("stream_level", level, 15);
         hs = s_ready;
         @(posedge clk);
         #1;
         if (hs) v++;
      end
      s_valid = 1'b0;
      drain("stream_drain_level");

      // pointer wrap with random stalls
      step();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) push_word(24'hC00000 + DW'(i) * 24'h010101);
            s_valid = 1'b0;
            done = 1'b1;
         end
         begin
            int n;
            n = 0;
            while (!done && n < 3000) begin
               m_ready = ($urandom_range(0, 1) == 1);
               step();
               n++;
            end
         end
      join
      drain("wrap_drain_level");
      chk("wrap_queue_empty", exp_q.size(), 0);

      // flush with push and pop in the same cycle
      step();
      m_ready = 1'b0;
      for (int i = 0; i < 7; i++) push_word(24'h300000 + DW'(i));
      s_valid = 1'b0;
      repeat (4) step();
      @(negedge clk);
      chk("pre_flush_level", level, 7);
      step();
      flush   = 1'b1;
      s_valid = 1'b1;
      s_data  = 24'hBAD000;
      m_ready = 1'b1;
      step();
      flush   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk("flush_level", level, 0);
      chk("flush_m_valid", m_valid, 0);
      chk("flush_s_ready", s_ready, 1);
      s_valid = 1'b1;
      s_data  = 24'h123456;
      step();
      s_valid = 1'b0;
      @(negedge clk);
      chk("post_flush_mvalid_n", m_valid, 0);
      @(negedge clk);
      chk("post_flush_mvalid_n1", m_valid, 0);
      @(negedge clk);
      chk("post_flush_mvalid_n2", m_valid, 1);
      chk("post_flush_mdata_n2", m_data, 24'h123456);
      step();

      // reset mid-stream
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(24'h400000 + DW'(i));
      s_valid = 1'b0;
      rst_n   = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_level", level, 0);
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_no_reappear", m_valid, 0);
      end
      step();
      push_word(24'h555555);
      push_word(24'h666666);
      s_valid = 1'b0;
      drain("midrst_drain_level");

      repeat (3) step();
      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pix_line_fifo.md
PIX_LINE_FIFO -- requirements
Module: pix_line_fifo

Interface
REQ-001 Parameter L, default 8, address width; capacity 2**L pixel words.
REQ-002 Parameter DW, default 24, pixel word width.
REQ-003 Parameter AF_THR, default 2**L-4, almost-full threshold in words.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous clear of all contents, active-high.
REQ-007 s_valid  input  1  upstream pixel valid.
REQ-008 s_data  input  DW  upstream pixel word.
REQ-009 s_ready  output  1  FIFO can accept a word this cycle.
REQ-010 m_valid  output  1  head word present on m_data.
REQ-011 m_data  output  DW  head word, first-word-fall-through.
REQ-012 m_ready  input  1  downstream consumes head word.
REQ-013 level  output  L+1  words held (RAM + pending read + output stage).
REQ-014 afull  output  1  level >= AF_THR.

Function
REQ-015 Push occurs when s_valid && s_ready; pop occurs when m_valid && m_ready.
REQ-016 s_ready SHALL be 1 iff level != 2**L; a pop in the same cycle SHALL NOT raise s_ready (no full-state pass-through).
REQ-017 Storage SHALL be a dual-port RAM of 2**L x DW: one write port, one read port with registered output and 1-cycle read latency.
REQ-018 wr_ptr and rd_ptr SHALL be L+1 bits; RAM address = low L bits; ram_cnt = wr_ptr - rd_ptr modulo 2**(L+1); both wrap naturally from 2**(L+1)-1 to 0.
REQ-019 Push writes s_data at wr_ptr and increments wr_ptr in the same cycle.
REQ-020 Output stage SHALL be a 2-entry skid (head, skid) plus a one-bit read-pending flag.
REQ-021 A RAM read SHALL issue when ram_cnt != 0 and (out_cnt + pend - pop) < 2, where out_cnt is occupied output entries; issue increments rd_ptr and sets pend for one cycle.
REQ-022 ram_cnt SHALL be evaluated on registered pointers, so a word is never read in its write cycle.
REQ-023 Returning read data SHALL load head if head is empty or being popped and skid is empty, otherwise skid; on pop with skid full, skid moves to head.
REQ-024 Latency: word pushed into an empty FIFO at cycle N SHALL present m_valid=1 with that word at cycle N+2.
REQ-025 Sustained s_valid=1, m_ready=1 SHALL give one word per cycle after initial latency, with no bubbles.
REQ-026 m_data SHALL hold stable while m_valid && !m_ready.
REQ-027 level SHALL increment on push, decrement on pop, and stay unchanged on simultaneous push and pop.
REQ-028 Order SHALL be strictly FIFO; no word is dropped or duplicated.
REQ-029 flush SHALL take priority over push and pop in the same cycle: pointers, pend, out_cnt and level are cleared next cycle; RAM contents are not cleared.

Reset
REQ-030 On clk edge with rst_n=0: wr_ptr=0, rd_ptr=0, pend=0, out_cnt=0, level=0.
REQ-031 Outputs during and after reset: s_ready=1, m_valid=0, m_data=0, afull=0 (AF_THR>0).
REQ-032 Reset asserted mid-transfer SHALL discard all stored words; any in-flight read return is ignored.

Structure
REQ-033 The RAM SHALL be a separate sub-module instance, the team's dual-port RAM Dul_Ram (L, DW), with both ports on clk.
REQ-034 No shared package is required; pointer-width and capacity constants are derived locally from L.

Verification (bench with L=4, DW=24, AF_THR=12)
REQ-035 Single push 0xA5A5A5 into empty FIFO at cycle N, m_ready=1 -> m_valid=1 with m_data=0xA5A5A5 at N+2; level 1 at N+1, 0 after the pop.
REQ-036 Push 16 words 0..15 with m_ready=0 -> s_ready=0 after 16th push; level=16; afull=1 from level 12; a 17th s_valid is not accepted.
REQ-037 Full FIFO, then m_ready=1 and s_valid=1 continuously -> exactly one word per cycle out, values 0,1,2,... in order; level holds steady.
REQ-038 Pointer wrap: 40 words streamed with random m_ready stalls -> output sequence equals input; m_data stable on every stall cycle.
REQ-039 flush asserted with level=7 and a push and pop in the same cycle -> next cycle level=0, m_valid=0, s_ready=1; subsequent push 0x123456 appears 2 cycles later.
REQ-040 rst_n=0 for one cycle mid-stream -> next cycle m_valid=0, level=0; prior words never reappear.
